// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with multi-cycle mult/div sequencing; decode registered, 1-cycle latency.
// Backpressure: ready drops for the N BUSY cycles of a mult/div; valid_in without ready is dropped.
`ifndef ALU_CTRL_MC_DEFS
`define ALU_CTRL_MC_DEFS
`define ALUOP_R_TYPE    3'd0
`define ALUOP_I_BEQ     3'd1
`define ALUOP_I_ORI     3'd2
`define ALUOP_I_LW      3'd3
`define ALUOP_I_SW      3'd4
`define ALUOP_J_JAL     3'd5
`define ALUOP_J_JMP     3'd6
`define FUNC_ADD        6'h20
`define FUNC_ADDU       6'h21
`define FUNC_SUBU       6'h23
`define FUNC_AND        6'h24
`define FUNC_OR         6'h25
`define FUNC_NOR        6'h27
`define FUNC_SLT        6'h2A
`define FUNC_SLTU       6'h2B
`define FUNC_MULT       6'h18
`define FUNC_MULTU      6'h19
`define FUNC_DIV        6'h1A
`define FUNC_DIVU       6'h1B
`define ALUSIGNAL_ADD   5'd1
`define ALUSIGNAL_ADDU  5'd2
`define ALUSIGNAL_SUBU  5'd3
`define ALUSIGNAL_AND   5'd4
`define ALUSIGNAL_OR    5'd5
`define ALUSIGNAL_NOR   5'd6
`define ALUSIGNAL_SLT   5'd7
`define ALUSIGNAL_SLTU  5'd8
`define ALUSIGNAL_MULT  5'd9
`define ALUSIGNAL_MULTU 5'd10
`define ALUSIGNAL_DIV   5'd11
`define ALUSIGNAL_DIVU  5'd12
`define ALUSIGNAL_BEQ   5'd13
`define ALUSIGNAL_ORI   5'd14
`define ALUSIGNAL_LW    5'd15
`define ALUSIGNAL_SW    5'd16
`define ALUSIGNAL_JAL   5'd17
`define ALUSIGNAL_JMP   5'd18
`endif

module alu_ctrl_mc #(
    parameter int SIGNAL_W   = 5,
    parameter int ALUOP_W    = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [ALUOP_W-1:0]  aluop,
    input  logic [5:0]          funct,
    output logic                ready,
    output logic                out_valid,
    output logic [SIGNAL_W-1:0] alu_signal,
    output logic                illegal,
    output logic                md_start,
    output logic                stall,
    output logic                done
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter holds remaining BUSY cycles minus one; leaving BUSY happens on the edge it reads zero.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t              state, state_nx;
    logic [5:0]          cnt, cnt_nx;
    logic [SIGNAL_W-1:0] sig_nx, dec_sig;
    logic                ov_nx, ill_nx, md_nx, done_nx;
    logic                dec_ill, dec_multi;
    logic [5:0]          dec_load;

    always_comb begin
        dec_sig   = '0;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_load  = '0;
        case (aluop)
            ALUOP_W'(`ALUOP_R_TYPE): begin
                case (funct)
                    `FUNC_ADD:   dec_sig = SIGNAL_W'(`ALUSIGNAL_ADD);
                    `FUNC_ADDU:  dec_sig = SIGNAL_W'(`ALUSIGNAL_ADDU);
                    `FUNC_SUBU:  dec_sig = SIGNAL_W'(`ALUSIGNAL_SUBU);
                    `FUNC_AND:   dec_sig = SIGNAL_W'(`ALUSIGNAL_AND);
                    `FUNC_OR:    dec_sig = SIGNAL_W'(`ALUSIGNAL_OR);
                    `FUNC_NOR:   dec_sig = SIGNAL_W'(`ALUSIGNAL_NOR);
                    `FUNC_SLT:   dec_sig = SIGNAL_W'(`ALUSIGNAL_SLT);
                    `FUNC_SLTU:  dec_sig = SIGNAL_W'(`ALUSIGNAL_SLTU);
                    `FUNC_MULT:  begin dec_sig = SIGNAL_W'(`ALUSIGNAL_MULT);  dec_multi = 1'b1; dec_load = MUL_LOAD; end
                    `FUNC_MULTU: begin dec_sig = SIGNAL_W'(`ALUSIGNAL_MULTU); dec_multi = 1'b1; dec_load = MUL_LOAD; end
                    `FUNC_DIV:   begin dec_sig = SIGNAL_W'(`ALUSIGNAL_DIV);   dec_multi = 1'b1; dec_load = DIV_LOAD; end
                    `FUNC_DIVU:  begin dec_sig = SIGNAL_W'(`ALUSIGNAL_DIVU);  dec_multi = 1'b1; dec_load = DIV_LOAD; end
                    default:     dec_ill = 1'b1;
                endcase
            end
            ALUOP_W'(`ALUOP_I_BEQ): dec_sig = SIGNAL_W'(`ALUSIGNAL_BEQ);
            ALUOP_W'(`ALUOP_I_ORI): dec_sig = SIGNAL_W'(`ALUSIGNAL_ORI);
            ALUOP_W'(`ALUOP_I_LW):  dec_sig = SIGNAL_W'(`ALUSIGNAL_LW);
            ALUOP_W'(`ALUOP_I_SW):  dec_sig = SIGNAL_W'(`ALUSIGNAL_SW);
            ALUOP_W'(`ALUOP_J_JAL): dec_sig = SIGNAL_W'(`ALUSIGNAL_JAL);
            ALUOP_W'(`ALUOP_J_JMP): dec_sig = SIGNAL_W'(`ALUSIGNAL_JMP);
            default:                dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sig_nx   = alu_signal;
        ov_nx    = 1'b0;
        ill_nx   = 1'b0;
        md_nx    = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                // flush outranks valid_in: an accept coinciding with flush is dropped
                if (valid_in && !flush) begin
                    ov_nx  = 1'b1;
                    sig_nx = dec_sig;
                    ill_nx = dec_ill;
                    if (dec_multi) begin
                        state_nx = BUSY;
                        cnt_nx   = dec_load;
                        md_nx    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == 6'd0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 6'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_signal <= '0;
            out_valid  <= 1'b0;
            illegal    <= 1'b0;
            md_start   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            alu_signal <= sig_nx;
            out_valid  <= ov_nx;
            illegal    <= ill_nx;
            md_start   <= md_nx;
            done       <= done_nx;
        end
    end

    assign ready = (state == IDLE);
    assign stall = (state == BUSY);

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Randomized and directed bench for alu_ctrl_mc against a cycle-level reference model.
module tb_alu_ctrl_mc;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    localparam logic [2:0] OP_R = 3'd0, OP_BEQ = 3'd1, OP_ORI = 3'd2, OP_LW = 3'd3,
                           OP_SW = 3'd4, OP_JAL = 3'd5, OP_JMP = 3'd6, OP_BAD = 3'd7;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                           F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic       clk = 1'b0;
    logic       rst, flush, valid_in;
    logic [2:0] aluop;
    logic [5:0] funct;
    logic       ready, out_valid, illegal, md_start, stall, done;
    logic [4:0] alu_signal;

    always #5 clk = ~clk;

    alu_ctrl_mc #(.SIGNAL_W(5), .ALUOP_W(3), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .aluop(aluop),
        .funct(funct), .ready(ready), .out_valid(out_valid), .alu_signal(alu_signal),
        .illegal(illegal), .md_start(md_start), .stall(stall), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: opcode table plus "stall cycles remaining" bookkeeping.
    int         m_busy;
    logic [4:0] m_sig;
    logic       m_ov, m_ill, m_md, m_done;

    function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                       output logic [4:0] sig, output logic ill, output int cyc);
        sig = 5'd0; ill = 1'b0; cyc = 0;
        if (op == OP_R) begin
            case (fn)
                F_ADD:   sig = 5'd1;
                F_ADDU:  sig = 5'd2;
                F_SUBU:  sig = 5'd3;
                F_AND:   sig = 5'd4;
                F_OR:    sig = 5'd5;
                F_NOR:   sig = 5'd6;
                F_SLT:   sig = 5'd7;
                F_SLTU:  sig = 5'd8;
                F_MULT:  begin sig = 5'd9;  cyc = MUL_N; end
                F_MULTU: begin sig = 5'd10; cyc = MUL_N; end
                F_DIV:   begin sig = 5'd11; cyc = DIV_N; end
                F_DIVU:  begin sig = 5'd12; cyc = DIV_N; end
                default: ill = 1'b1;
            endcase
        end else if (op == OP_BAD) begin
            ill = 1'b1;
        end else begin
            sig = 5'd12 + 5'(op);
        end
    endfunction

    task automatic model_edge();
        logic [4:0] s;
        logic       il;
        int         c;
        if (rst) begin
            m_busy = 0; m_sig = 0; m_ov = 0; m_ill = 0; m_md = 0; m_done = 0;
        end else begin
            m_ov = 0; m_ill = 0; m_md = 0; m_done = 0;
            if (m_busy > 0) begin
                if (flush) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) m_done = 1;
                end
            end else if (valid_in && !flush) begin
                ref_decode(aluop, funct, s, il, c);
                m_ov = 1; m_sig = s; m_ill = il;
                if (c > 0) begin m_busy = c; m_md = 1; end
            end
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [5:0] fn,
                        input logic fl, input logic r);
        valid_in = v; aluop = op; funct = fn; flush = fl; rst = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", {ready, stall, out_valid, illegal, md_start, done, alu_signal},
              {(m_busy == 0), (m_busy > 0), m_ov, m_ill, m_md, m_done, m_sig});
    endtask

    task automatic idle(); step(1'b0, OP_R, F_ADD, 1'b0, 1'b0); endtask

    // Called right after an accept step; counts cycles (accept+1 = 1) until done.
    task automatic wait_done(output int done_at, output int stall_cnt, output int md_cnt, output int bad);
        int k = 1;
        done_at = -1; stall_cnt = 0; md_cnt = 0; bad = 0;
        while (k < 200) begin
            stall_cnt += int'(stall);
            md_cnt    += int'(md_start);
            if (ready && stall) bad++;
            if (done) begin done_at = k; break; end
            idle();
            k++;
        end
    endtask

    logic [5:0] legal_f [12] = '{F_ADD, F_ADDU, F_SUBU, F_AND, F_OR, F_NOR, F_SLT, F_SLTU,
                                 F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin
        int da, sc, mc, bad, dn;
        logic       rv, rf, rr;
        logic [2:0] ro;
        logic [5:0] rfn;

        m_busy = 0; m_sig = 0; m_ov = 0; m_ill = 0; m_md = 0; m_done = 0;
        valid_in = 0; aluop = 0; funct = 0; flush = 0; rst = 1;

        step(1'b0, OP_R, F_ADD, 1'b0, 1'b1);
        step(1'b0, OP_R, F_ADD, 1'b0, 1'b1);
        check("reset_state", {ready, stall, out_valid, illegal, md_start, done, alu_signal}, 11'h400);

        step(1'b1, OP_R, F_ADD, 1'b0, 1'b0);
        check("add_valid", out_valid, 1);
        check("add_sig", alu_signal, 5'd1);
        check("add_stall", stall, 0);

        step(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
        check("mult_md", md_start, 1);
        wait_done(da, sc, mc, bad);
        check("mult_done_at", da, MUL_N + 1);
        check("mult_stall", sc, MUL_N);
        check("mult_md_cnt", mc, 1);
        check("mult_ready_hi", bad, 0);

        step(1'b1, OP_R, F_DIV, 1'b0, 1'b0);
        wait_done(da, sc, mc, bad);
        check("div_done_at", da, DIV_N + 1);
        check("div_stall", sc, DIV_N);
        step(1'b1, OP_R, F_ADDU, 1'b0, 1'b0);
        check("b2b_valid", out_valid, 1);
        check("b2b_sig", alu_signal, 5'd2);

        step(1'b1, OP_R, F_DIV, 1'b0, 1'b0);
        repeat (9) idle();
        step(1'b1, OP_R, F_SUBU, 1'b1, 1'b0);
        check("flush_ready", ready, 1);
        check("flush_valid", out_valid, 0);
        dn = 0;
        repeat (40) begin idle(); dn += int'(done); end
        check("flush_no_done", dn, 0);

        step(1'b1, OP_R, F_AND, 1'b1, 1'b0);
        check("idle_flush_drop", out_valid, 0);
        check("sig_hold", alu_signal, 5'd11);

        step(1'b1, OP_R, 6'h3F, 1'b0, 1'b0);
        check("ill_sig", alu_signal, 0);
        check("ill_flag", illegal, 1);
        step(1'b1, OP_ORI, F_ADD, 1'b0, 1'b0);
        check("ori_sig", alu_signal, 5'd14);
        check("ori_ill", illegal, 0);
        step(1'b1, OP_BAD, F_ADD, 1'b0, 1'b0);
        check("bad_op_ill", {illegal, stall, alu_signal}, 7'h40);

        step(1'b1, OP_R, F_MULT, 1'b0, 1'b0);
        idle();
        step(1'b0, OP_R, F_ADD, 1'b0, 1'b1);
        check("rst_busy", {ready, stall, out_valid, illegal, md_start, done, alu_signal}, 11'h400);
        dn = 0;
        repeat (8) begin idle(); dn += int'(done) + int'(md_start); end
        check("rst_no_done", dn, 0);

        repeat (3000) begin
            rv = ($urandom_range(0, 9) < 7);
            ro = ($urandom_range(0, 1) == 0) ? OP_R : 3'($urandom_range(0, 7));
            rfn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 11)];
            rf = ($urandom_range(0, 99) < 3);
            rr = ($urandom_range(0, 199) == 0);
            step(rv, ro, rfn, rf, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
